// File: rtl/fpu_wb_sched_if.sv
// rtl/fpu_wb_sched_if.sv - issue request and writeback bundle between decode and the FP scheduler
interface fpu_wb_sched_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic [3:0]       issue_en;
  logic             flush;
  logic             wb_valid;
  logic [1:0]       wb_op;
  logic [TAG_W-1:0] wb_tag;
  logic [3:0]       inflight;
  logic             busy;

  modport master (
    output req_valid, req_op, req_tag, flush,
    input  req_ready, issue_en, wb_valid, wb_op, wb_tag, inflight, busy
  );

  modport slave (
    input  req_valid, req_op, req_tag, flush,
    output req_ready, issue_en, wb_valid, wb_op, wb_tag, inflight, busy
  );
endinterface

// File: rtl/fpu_wb_sched.sv
// rtl/fpu_wb_sched.sv - FP issue scheduler sequencing the single register-file write port
module fpu_wb_sched #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_MADD = 5,
  parameter int LAT_MOV  = 1,
  parameter int LAT_MAX  = 8,
  parameter int TAG_W    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_wb_sched_if.slave bus
);

  // Reservation table: slot k writes back k edges from now.
  logic [LAT_MAX:1] vld_q, vld_d;
  logic [1:0]       op_q  [1:LAT_MAX];
  logic [1:0]       op_d  [1:LAT_MAX];
  logic [TAG_W-1:0] tag_q [1:LAT_MAX];
  logic [TAG_W-1:0] tag_d [1:LAT_MAX];

  logic             wb_valid_q, wb_valid_d;
  logic [1:0]       wb_op_q, wb_op_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [3:0]       inflight_q, inflight_d;

  int   lat;
  logic slot_conflict;
  logic tag_conflict;
  logic accept;

  // Latency of the offered op class
  always_comb begin
    lat = LAT_ADD;
    case (bus.req_op)
      2'd0:    lat = LAT_ADD;
      2'd1:    lat = LAT_MUL;
      2'd2:    lat = LAT_MADD;
      default: lat = LAT_MOV;
    endcase
  end

  // Write-port collision (slot L+1 shifts into L) and WAW hazard on any pending tag
  always_comb begin
    slot_conflict = 1'b0;
    tag_conflict  = 1'b0;
    for (int k = 1; k < LAT_MAX; k++) begin
      if (lat == k && vld_q[k+1]) slot_conflict = 1'b1;
    end
    for (int k = 1; k <= LAT_MAX; k++) begin
      if (vld_q[k] && tag_q[k] == bus.req_tag) tag_conflict = 1'b1;
    end
  end

  // Ready never looks at req_valid so decode can use it to steer
  assign bus.req_ready = !bus.flush && !slot_conflict && !tag_conflict &&
                         (int'(inflight_q) < LAT_MAX);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.issue_en  = accept ? (4'b0001 << bus.req_op) : 4'b0000;

  // Shift the table, insert the accepted op at its latency, account writebacks
  always_comb begin
    for (int k = 1; k < LAT_MAX; k++) begin
      vld_d[k] = vld_q[k+1];
      op_d[k]  = op_q[k+1];
      tag_d[k] = tag_q[k+1];
    end
    vld_d[LAT_MAX] = 1'b0;
    op_d[LAT_MAX]  = '0;
    tag_d[LAT_MAX] = '0;
    if (accept) begin
      for (int k = 1; k <= LAT_MAX; k++) begin
        if (lat == k) begin
          vld_d[k] = 1'b1;
          op_d[k]  = bus.req_op;
          tag_d[k] = bus.req_tag;
        end
      end
    end
    // A flush drops every pending strobe, including the one leaving slot 1 now
    if (bus.flush) vld_d = '0;

    wb_valid_d = vld_q[1] && !bus.flush;
    wb_op_d    = wb_valid_d ? op_q[1]  : 2'd0;
    wb_tag_d   = wb_valid_d ? tag_q[1] : '0;

    if (bus.flush) inflight_d = 4'd0;
    else           inflight_d = inflight_q + {3'b000, accept} - {3'b000, vld_q[1]};
  end

  // State registers; reset discards everything in flight without a writeback
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int k = 1; k <= LAT_MAX; k++) begin
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_op_q    <= 2'd0;
      wb_tag_q   <= '0;
      inflight_q <= 4'd0;
    end else begin
      vld_q <= vld_d;
      for (int k = 1; k <= LAT_MAX; k++) begin
        op_q[k]  <= op_d[k];
        tag_q[k] <= tag_d[k];
      end
      wb_valid_q <= wb_valid_d;
      wb_op_q    <= wb_op_d;
      wb_tag_q   <= wb_tag_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_op    = wb_op_q;
  assign bus.wb_tag   = wb_tag_q;
  assign bus.inflight = inflight_q;
  assign bus.busy     = (inflight_q != 4'd0);

endmodule
